pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide parameter RA_W, default 5: register-index width.
REQ-002 SHALL provide parameter STRB_W, default 4: data-memory byte-strobe width, power of two, at least 4.
REQ-003 SHALL provide parameter LU_BUBBLES, default 1: load-use bubbles inserted, legal range 1..3.
REQ-004 SHALL provide ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- d_valid  in  1  D-stage instruction valid.
- opcode  in  5  D-stage opcode[6:2].
- f3  in  3  D-stage funct3.
- f7  in  1  D-stage funct7[5].
- rs1, rs2, rd  in  RA_W each  D-stage register indices.
- alu_out  in  1  E-stage branch-compare result.
- dm_ready  in  1  data memory ready; 0 freezes the pipeline.
- stall  out  1  hold F/D.
- flush  out  1  kill D instruction.
- next_pc_sel  out  1  redirect PC to jump/branch target.
- D_rs1_data_sel, D_rs2_data_sel  out  1 each  1 = W writeback bypass into D.
- E_rs1_data_sel, E_rs2_data_sel  out  2 each  1 = from M, 0 = from W, 2 = from register.
- E_jb_op1_sel, E_alu_op1_sel, E_alu_op2_sel  out  1 each  operand selects.
- E_op  out  5;  E_f3  out  3;  E_f7  out  1.
- M_dm_w_en  out  STRB_W  store byte strobes.
- W_wb_en  out  1  register-file write enable.
- W_rd_index  out  RA_W  write-back index.
- W_wb_data_sel  out  1  0 = load data, 1 = ALU result.
- stall_count  out  16  saturating count of stall cycles.

Function
REQ-005 SHALL hold E, M and W stage registers: valid, op, f3, f7 (E only), rs1/rs2 (E only), rd.
REQ-006 SHALL define a bubble as valid=0, op=00100, f3=0, f7=0, rs1=rs2=rd=0.
REQ-007 SHALL define "writes rd" as valid, op not STORE(01000) and not Btype(11000), and rd != 0.
REQ-008 SHALL treat D as using rs1 for Btype, LOAD, STORE, Itype, Rtype and JALR, and using rs2 for Btype, STORE and Rtype; E uses rs1/rs2 under the same rule.
REQ-009 SHALL implement an FSM with states RUN, LU_STALL and FREEZE.
REQ-010 SHALL, in RUN with dm_ready=1 and no hazard, advance D->E (valid=d_valid), E->M and M->W on every clock.
REQ-011 SHALL detect load-use when E is valid, E op is LOAD, D is valid, and a used D source equals E_rd with E_rd != 0.
REQ-012 SHALL, on load-use in RUN, assert stall combinationally, insert a bubble into E, advance M and W, and load the bubble counter with LU_BUBBLES-1.
REQ-013 SHALL enter LU_STALL if LU_BUBBLES>1, else remain in RUN.
REQ-014 SHALL, in LU_STALL, keep stall=1, insert a bubble each cycle, decrement the counter, and return to RUN on the cycle the counter is 0.
REQ-015 SHALL assert next_pc_sel when E is valid and dm_ready=1 and either (E op Btype and alu_out=1) or E op is JAL(11011) or JALR(11001).
REQ-016 SHALL, when next_pc_sel=1, assert flush, put a bubble into E on the next edge, and ignore any load-use stall that cycle; taken branch has priority.
REQ-017 SHALL, when dm_ready=0 in any state, enter FREEZE: all stage registers and the bubble counter hold, stall=1, next_pc_sel=0, flush=0.
REQ-018 SHALL leave FREEZE on the first edge with dm_ready=1 and return to the state it was frozen from.
REQ-019 SHALL set E_rsX_data_sel to 1 if M writes rd and M_rd equals E_rsX, else 0 if W writes rd and W_rd equals E_rsX, else 2, counting only sources E uses; M has priority over W.
REQ-020 SHALL set D_rsX_data_sel=1 when D uses rsX, W writes rd, and W_rd equals rsX.
REQ-021 SHALL decode the E outputs combinationally:
- E_alu_op1_sel=1 for AUIPC, JAL and JALR.
- E_alu_op2_sel=0 for Rtype and Btype, else 1.
- E_jb_op1_sel=0 for JAL and Btype, else 1.
REQ-022 SHALL drive W_wb_en=1 exactly when W writes rd; W_rd_index=W_rd; W_wb_data_sel=0 for LOAD, else 1.
REQ-023 SHALL drive M_dm_w_en=0 unless M is valid with op STORE; then by f3[1:0]: 00 -> lowest 1 bit, 01 -> lowest 2 bits, 10 -> lowest 4 bits, 11 -> all ones.
REQ-024 SHALL increment stall_count on every clock with stall=1 and saturate at 16'hFFFF.

Reset
REQ-025 SHALL, while rst=0 and independent of clk, set state RUN, all stages to bubble, bubble counter 0 and stall_count 0.
REQ-026 SHALL hold during reset: stall=0, flush=0, next_pc_sel=0, W_wb_en=0, M_dm_w_en=0, E_rs1_data_sel=E_rs2_data_sel=2, D_rs1_data_sel=D_rs2_data_sel=0, E_op=00100.
REQ-027 SHALL discard any in-progress LU_STALL or FREEZE when rst is asserted.

Verification
REQ-028 Load-use, LU_BUBBLES=1: LOAD rd=5 in E, D Rtype rs1=5 -> stall=1 for 1 cycle, E bubble, then E_rs1_data_sel=0 (from W) when consumer reaches E.
REQ-029 Load-use, LU_BUBBLES=3: same stimulus -> stall=1 for exactly 3 cycles, stall_count=3.
REQ-030 Back-to-back ALU: ADD x3, then SUB rs1=x3 -> E_rs1_data_sel=1; a third instruction using x3 -> E_rs1_data_sel=0; rd=x0 producer -> select 2.
REQ-031 Taken BEQ (alu_out=1) while D holds a LOAD-dependent instruction -> next_pc_sel=1, flush=1, stall=0, E bubble next cycle.
REQ-032 dm_ready=0 for 4 cycles mid LU_STALL -> stages frozen, next_pc_sel=0, bubble count resumes exactly after release, stall_count +4.
REQ-033 SB/SH/SW with STRB_W=8 -> M_dm_w_en 0x01/0x03/0x0F; rst pulsed low mid-stall -> all outputs at REQ-026 values immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline control for a 5-stage in-order RISC-V style core:
// E/M/W stage tracking, load-use bubbles, branch flush, memory freeze and forwarding selects.
module pipe_hazard_ctrl #(
  parameter int unsigned RA_W       = 5,
  parameter int unsigned STRB_W     = 4,
  parameter int unsigned LU_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  input  logic [4:0]        opcode,
  input  logic [2:0]        f3,
  input  logic              f7,
  input  logic [RA_W-1:0]   rs1,
  input  logic [RA_W-1:0]   rs2,
  input  logic [RA_W-1:0]   rd,
  input  logic              alu_out,
  input  logic              dm_ready,
  output logic              stall,
  output logic              flush,
  output logic              next_pc_sel,
  output logic              D_rs1_data_sel,
  output logic              D_rs2_data_sel,
  output logic [1:0]        E_rs1_data_sel,
  output logic [1:0]        E_rs2_data_sel,
  output logic              E_jb_op1_sel,
  output logic              E_alu_op1_sel,
  output logic              E_alu_op2_sel,
  output logic [4:0]        E_op,
  output logic [2:0]        E_f3,
  output logic              E_f7,
  output logic [STRB_W-1:0] M_dm_w_en,
  output logic              W_wb_en,
  output logic [RA_W-1:0]   W_rd_index,
  output logic              W_wb_data_sel,
  output logic [15:0]       stall_count
);

  localparam int unsigned OP_W  = 5;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned SC_W  = 16;

  localparam logic [OP_W-1:0] OP_LOAD  = 5'b00000;
  localparam logic [OP_W-1:0] OP_IMM   = 5'b00100;
  localparam logic [OP_W-1:0] OP_AUIPC = 5'b00101;
  localparam logic [OP_W-1:0] OP_STORE = 5'b01000;
  localparam logic [OP_W-1:0] OP_REG   = 5'b01100;
  localparam logic [OP_W-1:0] OP_BR    = 5'b11000;
  localparam logic [OP_W-1:0] OP_JALR  = 5'b11001;
  localparam logic [OP_W-1:0] OP_JAL   = 5'b11011;

  typedef enum logic [1:0] {RUN, LU_STALL, FREEZE} state_t;

  function automatic logic uses_rs1(input logic [OP_W-1:0] op);
    return op inside {OP_BR, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_JALR};
  endfunction

  function automatic logic uses_rs2(input logic [OP_W-1:0] op);
    return op inside {OP_BR, OP_STORE, OP_REG};
  endfunction

  function automatic logic writes_rd(input logic v, input logic [OP_W-1:0] op,
                                     input logic [RA_W-1:0] r);
    return v && (op != OP_STORE) && (op != OP_BR) && (r != '0);
  endfunction

  state_t state_q, state_d, ret_q, ret_d, eff_state;

  logic              e_valid, e_f7;
  logic [OP_W-1:0]   e_op;
  logic [2:0]        e_f3;
  logic [RA_W-1:0]   e_rs1, e_rs2, e_rd;
  logic              m_valid;
  logic [OP_W-1:0]   m_op;
  logic [1:0]        m_sz;
  logic [RA_W-1:0]   m_rd;
  logic              w_valid;
  logic [OP_W-1:0]   w_op;
  logic [RA_W-1:0]   w_rd;
  logic [CNT_W-1:0]  cnt_q;
  logic [SC_W-1:0]   stall_cnt_q;

  logic take, load_use, m_wr, w_wr, e_use1, e_use2;
  logic stall_i, flush_i, adv, e_from_d, cnt_load, cnt_dec;
  logic [STRB_W-1:0] strb;

  assign m_wr   = writes_rd(m_valid, m_op, m_rd);
  assign w_wr   = writes_rd(w_valid, w_op, w_rd);
  assign e_use1 = uses_rs1(e_op);
  assign e_use2 = uses_rs2(e_op);

  assign take = e_valid && dm_ready &&
                (((e_op == OP_BR) && alu_out) || (e_op == OP_JAL) || (e_op == OP_JALR));

  assign load_use = e_valid && (e_op == OP_LOAD) && d_valid && (e_rd != '0) &&
                    ((uses_rs1(opcode) && (rs1 == e_rd)) ||
                     (uses_rs2(opcode) && (rs2 == e_rd)));

  // A release cycle behaves exactly like the state that was frozen
  assign eff_state = (state_q == FREEZE) ? ret_q : state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    if (!dm_ready) begin
      state_d = FREEZE;
      ret_d   = eff_state;
    end else begin
      case (eff_state)
        LU_STALL: state_d = (cnt_q <= CNT_W'(1)) ? RUN : LU_STALL;
        default:  state_d = (!take && load_use && (LU_BUBBLES > 1)) ? LU_STALL : RUN;
      endcase
    end
  end

  // Pipeline control; taken branch beats load-use
  always_comb begin
    stall_i  = 1'b0;
    flush_i  = 1'b0;
    adv      = 1'b0;
    e_from_d = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (!dm_ready) begin
      stall_i = 1'b1;
    end else begin
      adv = 1'b1;
      case (eff_state)
        LU_STALL: begin
          stall_i = 1'b1;
          cnt_dec = 1'b1;
        end
        default: begin
          if (take) begin
            flush_i = 1'b1;
          end else if (load_use) begin
            stall_i  = 1'b1;
            cnt_load = 1'b1;
          end else begin
            e_from_d = 1'b1;
          end
        end
      endcase
    end
  end

  assign stall       = stall_i && rst;
  assign flush       = flush_i;
  assign next_pc_sel = take;

  // Stage registers; E takes a bubble whenever D is not issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_valid <= 1'b0; e_op <= OP_IMM; e_f3 <= '0; e_f7 <= 1'b0;
      e_rs1   <= '0;   e_rs2 <= '0;    e_rd <= '0;
      m_valid <= 1'b0; m_op <= OP_IMM; m_sz <= '0; m_rd <= '0;
      w_valid <= 1'b0; w_op <= OP_IMM; w_rd <= '0;
    end else if (adv) begin
      m_valid <= e_valid; m_op <= e_op; m_sz <= e_f3[1:0]; m_rd <= e_rd;
      w_valid <= m_valid; w_op <= m_op; w_rd <= m_rd;
      if (e_from_d) begin
        e_valid <= d_valid; e_op <= opcode; e_f3 <= f3; e_f7 <= f7;
        e_rs1   <= rs1;     e_rs2 <= rs2;   e_rd <= rd;
      end else begin
        e_valid <= 1'b0; e_op <= OP_IMM; e_f3 <= '0; e_f7 <= 1'b0;
        e_rs1   <= '0;   e_rs2 <= '0;    e_rd <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (cnt_load) begin
        cnt_q <= CNT_W'(LU_BUBBLES - 1);
      end else if (cnt_dec && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + SC_W'(1);
      end
    end
  end

  assign stall_count = stall_cnt_q;

  // Forwarding: M beats W, only for sources the instruction actually reads
  assign E_rs1_data_sel = (e_use1 && m_wr && (m_rd == e_rs1)) ? 2'd1 :
                          (e_use1 && w_wr && (w_rd == e_rs1)) ? 2'd0 : 2'd2;
  assign E_rs2_data_sel = (e_use2 && m_wr && (m_rd == e_rs2)) ? 2'd1 :
                          (e_use2 && w_wr && (w_rd == e_rs2)) ? 2'd0 : 2'd2;
  assign D_rs1_data_sel = uses_rs1(opcode) && w_wr && (w_rd == rs1);
  assign D_rs2_data_sel = uses_rs2(opcode) && w_wr && (w_rd == rs2);

  assign E_alu_op1_sel = (e_op == OP_AUIPC) || (e_op == OP_JAL) || (e_op == OP_JALR);
  assign E_alu_op2_sel = !((e_op == OP_REG) || (e_op == OP_BR));
  assign E_jb_op1_sel  = !((e_op == OP_JAL) || (e_op == OP_BR));
  assign E_op          = e_op;
  assign E_f3          = e_f3;
  assign E_f7          = e_f7;

  always_comb begin
    strb = '0;
    if (m_valid && (m_op == OP_STORE)) begin
      case (m_sz)
        2'b00:   strb = STRB_W'(1);
        2'b01:   strb = STRB_W'(3);
        2'b10:   strb = STRB_W'(15);
        default: strb = '1;
      endcase
    end
  end

  assign M_dm_w_en     = strb;
  assign W_wb_en       = w_wr;
  assign W_rd_index    = w_rd;
  assign W_wb_data_sel = (w_op != OP_LOAD);

endmodule
